spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter TURN_CYCLES, default 1: number of idle cycles between the last MOSI bit of a read-data frame and the first MISO sample.
REQ-002 Parameter GAP_CYCLES, default 1: minimum number of cycles ss_n is held high between frames.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_op  input  2  op code: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
REQ-007 cmd_data  input  8  address or data byte to send.
REQ-008 cmd_ready  output  1  high when a command can be accepted.
REQ-009 ss_n  output  1  slave select to the SPI slave, active low, registered.
REQ-010 MOSI  output  1  serial data to the slave, registered.
REQ-011 MISO  input  1  serial data from the slave.
REQ-012 rd_data  output  8  byte received by the last read-data frame.
REQ-013 rd_valid  output  1  one-cycle pulse marking rd_data as updated.
REQ-014 busy  output  1  high whenever the block is not in IDLE.

Function
REQ-015 The state machine SHALL have the states IDLE, START, SELECT, SHIFT, TURN, RECV and GAP.
REQ-016 In IDLE: cmd_ready=1, ss_n=1, MOSI=0; cmd_valid&&cmd_ready latches {cmd_op,cmd_data} into a 10-bit frame register and moves to START.
REQ-017 cmd_ready SHALL be 0 in every state other than IDLE; cmd_valid outside IDLE is ignored and never queued.
REQ-018 START, 1 cycle: ss_n=0, MOSI=0 (slave leaves its idle state).
REQ-019 SELECT, 1 cycle: ss_n=0, MOSI=cmd_op[1] (0 selects the write path, 1 the read path).
REQ-020 SHIFT, 10 cycles: ss_n=0, MOSI=frame[9] down to frame[0], MSB first, one bit per clk; a 4-bit counter runs 0..9.
REQ-021 After SHIFT, ops 00/01/10 go to GAP; total ss_n-low time is exactly 12 cycles.
REQ-022 After SHIFT, op 11 goes to TURN for TURN_CYCLES cycles with ss_n=0 and MOSI=0, then to RECV.
REQ-023 RECV, 8 cycles: ss_n=0; MISO is sampled on each rising edge into a shift register, MSB first; the total ss_n-low time is 12+TURN_CYCLES+8 (21 by default).
REQ-024 On the RECV-to-GAP transition, rd_data takes the 8 shifted bits and rd_valid pulses high for exactly 1 cycle.
REQ-025 rd_data SHALL hold its value until the next read-data completion; write and read-address ops never change rd_data or rd_valid.
REQ-026 GAP: ss_n=1, MOSI=0, for GAP_CYCLES cycles, then IDLE; back-to-back commands are therefore separated by at least GAP_CYCLES ss_n-high cycles plus 1 IDLE cycle.
REQ-027 ss_n SHALL never glitch: it is low continuously from START through the end of SHIFT/RECV.
REQ-028 busy = (state != IDLE); busy and cmd_ready are mutually exclusive and never both 0 outside reset.

Reset
REQ-029 rst high at any rising edge SHALL force state=IDLE, ss_n=1, MOSI=0, rd_data=8'h00, rd_valid=0, counters=0 on that edge, including mid-frame (the frame is aborted and not resumed).
REQ-030 While rst is high, cmd_ready=0; in the first cycle after rst deasserts, cmd_ready=1.

Verification
REQ-031 Write-address: op=00, data=8'hA5 -> ss_n low 12 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1; rd_valid stays 0.
REQ-032 Write-data then read-address back-to-back (cmd_valid held high): op=01 data=8'h3C, then op=10 data=8'h3C -> two 12-cycle frames separated by exactly 1 ss_n-high GAP cycle plus 1 IDLE cycle; the select bits are 0 and 1 respectively.
REQ-033 Read-data: op=11, model slave drives 8'hE9 MSB first on MISO after the turnaround -> ss_n low 21 cycles, rd_data=8'hE9, rd_valid pulses once, on the cycle ss_n rises.
REQ-034 Reset mid-frame: assert rst during SHIFT bit 5 of op=11 -> next edge ss_n=1, MOSI=0, rd_valid=0, rd_data unchanged at 8'h00; after release, a fresh op=00 frame completes normally.
REQ-035 Ignored request: pulse cmd_valid with op=01 while busy -> no extra frame; ss_n-low cycle count matches only the accepted command.
REQ-036 Parameter check: TURN_CYCLES=2, GAP_CYCLES=3, op=11, MISO byte 8'h5A -> ss_n low 22 cycles, rd_data=8'h5A, ss_n high for 3 cycles before cmd_ready returns to 1.

Source files
------------

// File: rtl/spi_master_if.sv
// Command, read-back and SPI pin bundle between a host and spi_master.
interface spi_master_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       ss_n;
    logic       MOSI;
    logic       MISO;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, ss_n, MOSI, rd_data, rd_valid, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, ss_n, MOSI, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/spi_master.sv
// Single-command SPI master: start bit, select bit, 10-bit op/data frame, optional 8-bit readback.
// TURN_CYCLES and GAP_CYCLES are expected to be at least 1.
module spi_master #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {
        StIdle, StStart, StSelect, StShift, StTurn, StRecv, StGap
    } state_e;

    localparam logic [15:0] TurnLast = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] GapLast  = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  frame_q, frame_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic [3:0]  bit_idx;
    logic        cmd_ready;

    assign cmd_ready = (state_q == StIdle) && !rst;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready) begin
                    frame_d = {bus.cmd_op, bus.cmd_data};
                    state_d = StStart;
                end
            end
            StStart:  state_d = StSelect;
            StSelect: begin
                bit_cnt_d = 4'd0;
                state_d   = StShift;
            end
            StShift: begin
                if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d  = 4'd0;
                    wait_cnt_d = 16'd0;
                    state_d    = (frame_q[9:8] == 2'b11) ? StTurn : StGap;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            StTurn: begin
                if (wait_cnt_q == TurnLast) begin
                    bit_cnt_d = 4'd0;
                    state_d   = StRecv;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StRecv: begin
                rx_d = {rx_q[6:0], bus.MISO};
                if (bit_cnt_q == 4'd7) begin
                    rd_data_d  = {rx_q[6:0], bus.MISO};
                    rd_valid_d = 1'b1;
                    wait_cnt_d = 16'd0;
                    bit_cnt_d  = 4'd0;
                    state_d    = StGap;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            StGap: begin
                if (wait_cnt_q == GapLast) begin
                    wait_cnt_d = 16'd0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pin values are derived from the next state so they register in step with it.
        bit_idx = 4'd9 - bit_cnt_d;
        ss_n_d  = (state_d == StIdle) || (state_d == StGap);
        mosi_d  = 1'b0;
        case (state_d)
            StSelect: mosi_d = frame_d[9];
            StShift:  mosi_d = frame_d[bit_idx];
            default:  mosi_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            frame_q    <= 10'd0;
            bit_cnt_q  <= 4'd0;
            wait_cnt_q <= 16'd0;
            rx_q       <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.ss_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = (state_q != StIdle);
endmodule
